cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4: number of functional units (FUs) producing results; must be at least 2.
REQ-002 Parameter BIT_WIDTH, default 32: width of each result value.
REQ-003 Parameter TAG_WIDTH, default 8: width of each result tag.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 fu_resValid  input  NUM_FU  FU i presents a completed result this cycle.
REQ-007 fu_resTag  input  TAG_WIDTH x NUM_FU (unpacked)  tag of FU i's result.
REQ-008 fu_resValue  input  BIT_WIDTH x NUM_FU (unpacked)  value of FU i's result.
REQ-009 fu_resAccept  output  NUM_FU  the arbiter takes FU i's result at this edge if fu_resValid[i] is also high.
REQ-010 cdb_tag  output  TAG_WIDTH  broadcast tag; this drives the reservation-station funcUnitTags[0] input.
REQ-011 cdb_value  output  BIT_WIDTH  broadcast value; this drives funcUnitOut[0].
REQ-012 cdb_valid  output  1  broadcast is valid this cycle; this drives valueReady[0].
REQ-013 busy  output  1  at least one result is held pending.

Function
REQ-014 The block SHALL hold one pending entry per FU, each entry being {pending bit, tag, value}.
REQ-015 fu_resAccept[i] SHALL equal (!pending[i] || grant[i]).
  - It is combinational from state and grant only.
  - It SHALL NOT depend on fu_resValid.
REQ-016 On a clock edge where fu_resValid[i] && fu_resAccept[i], entry i SHALL capture tag and value and set pending[i]=1.
REQ-017 Each cycle, grant SHALL be one-hot or zero.
  - The granted entry is the first pending entry found scanning indices rrPtr, rrPtr+1, ... modulo NUM_FU.
  - grant is zero only when no entry is pending.
REQ-018 At an edge with a grant to entry g:
  - cdb_tag and cdb_value SHALL load entry g's tag and value, and cdb_valid SHALL become 1.
  - pending[g] SHALL clear, unless entry g captures a new result at the same edge.
  - rrPtr SHALL become (g+1) mod NUM_FU.
REQ-019 At an edge with no grant:
  - cdb_valid SHALL become 0.
  - cdb_tag and cdb_value SHALL hold their previous values.
  - rrPtr SHALL hold.
REQ-020 Simultaneous grant and capture on the same entry SHALL both take effect.
  - The old entry is broadcast and the new result is stored, with pending[g]=1.
  - This gives each FU a sustained throughput of one result per cycle when it is the only FU requesting.
REQ-021 Latency:
  - A result captured at edge N SHALL appear on the CDB (cdb_valid=1) no earlier than the cycle following edge N+1.
  - When competing with K other pending entries, it appears no later than the cycle following edge N+1+K.
REQ-022 cdb_valid SHALL be high for exactly one cycle per granted entry; no result is ever broadcast twice or dropped.
REQ-023 busy SHALL equal the OR of all pending bits, taken from registered state.
REQ-024 rrPtr SHALL be $clog2(NUM_FU) bits wide, and its wrap from NUM_FU-1 to 0 SHALL be explicit so that non-power-of-two NUM_FU works.
REQ-025 Tags SHALL be carried unmodified; a tag value of 0 has no special meaning to this block.

Reset
REQ-026 While reset=1 at an edge:
  - all pending bits SHALL clear;
  - rrPtr SHALL become 0;
  - cdb_valid, cdb_tag and cdb_value SHALL become 0;
  - busy SHALL become 0.
REQ-027 Reset mid-operation SHALL discard all pending results.
  - No broadcast SHALL occur in the cycle following the reset edge.
  - fu_resAccept SHALL be all-ones in that cycle.
REQ-028 fu_resValid asserted during reset SHALL NOT be captured.

Verification
REQ-029 Single result: FU1 presents valid with tag 0x05, value 0xDEADBEEF, for one cycle -> cdb_valid=1 with tag 0x05 and value 0xDEADBEEF for exactly one cycle, two edges after capture; busy is 1 for one cycle.
REQ-030 All four FUs present results at once (tags 0x10, 0x11, 0x12, 0x13) with rrPtr=0 -> broadcasts appear in the order 0x10, 0x11, 0x12, 0x13 on consecutive cycles, and rrPtr ends at 0.
REQ-031 Fairness: FU0 holds valid every cycle with incrementing tags while FU2 presents tag 0x22 once -> 0x22 is broadcast within 2 cycles of its capture, and FU0's results are all broadcast in order with none lost.
REQ-032 Back-to-back: FU3 alone is valid for 8 consecutive cycles with tags 0x30 to 0x37 -> fu_resAccept[3] stays 1 throughout, and cdb_valid stays high for 8 consecutive cycles carrying 0x30 to 0x37.
REQ-033 Reset mid-operation: assert reset while 3 entries are pending -> in the next cycle cdb_valid=0, busy=0, fu_resAccept=4'b1111, and none of those 3 tags ever appears on the CDB.
REQ-034 Wrap-around with NUM_FU=3: FU2 is granted, then FU0 and FU1 both become pending -> FU0 is granted next (rrPtr wrapped from 2 to 0).

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one pending slot per functional unit,
// round-robin broadcast of one result per cycle onto the CDB.
module cdb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int BIT_WIDTH = 32,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_FU-1:0]    fu_resValid,
  input  logic [TAG_WIDTH-1:0] fu_resTag   [NUM_FU],
  input  logic [BIT_WIDTH-1:0] fu_resValue [NUM_FU],
  output logic [NUM_FU-1:0]    fu_resAccept,
  output logic [TAG_WIDTH-1:0] cdb_tag,
  output logic [BIT_WIDTH-1:0] cdb_value,
  output logic                 cdb_valid,
  output logic                 busy
);

  localparam int PW = $clog2(NUM_FU);
  localparam logic [PW-1:0] LAST = PW'(NUM_FU - 1);

  logic [NUM_FU-1:0]    pend;
  logic [NUM_FU-1:0]    grant;
  logic [TAG_WIDTH-1:0] e_tag [NUM_FU];
  logic [BIT_WIDTH-1:0] e_val [NUM_FU];
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        g_idx;
  logic [PW-1:0]        nxt_ptr;
  logic [PW-1:0]        scan_idx;
  logic                 g_any;

  // Scan from rr_ptr with an explicit wrap so odd NUM_FU works.
  always_comb begin
    grant    = '0;
    g_idx    = '0;
    g_any    = 1'b0;
    scan_idx = rr_ptr;
    for (int k = 0; k < NUM_FU; k++) begin
      if (!g_any && pend[scan_idx]) begin
        g_any           = 1'b1;
        g_idx           = scan_idx;
        grant[scan_idx] = 1'b1;
      end
      scan_idx = (scan_idx == LAST) ? '0 : scan_idx + 1'b1;
    end
  end

  assign nxt_ptr      = (g_idx == LAST) ? '0 : g_idx + 1'b1;
  assign fu_resAccept = ~pend | grant;
  assign busy         = |pend;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_resValid[i] && fu_resAccept[i]) begin
        e_tag[i] <= fu_resTag[i];
        e_val[i] <= fu_resValue[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= '0;
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
    end else begin
      // A capture on the granted slot wins over the grant's clear.
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_resValid[i] && fu_resAccept[i])
          pend[i] <= 1'b1;
        else if (grant[i])
          pend[i] <= 1'b0;
      end
      if (g_any) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= e_tag[g_idx];
        cdb_value <= e_val[g_idx];
        rr_ptr    <= nxt_ptr;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a 4-FU instance and
// a 3-FU instance for the odd-size round-robin wrap.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        reset;

  logic [3:0]  valid4;
  logic [7:0]  tag4 [4];
  logic [31:0] val4 [4];
  logic [3:0]  acc4;
  logic [7:0]  ctag4;
  logic [31:0] cval4;
  logic        cvld4;
  logic        busy4;

  logic [2:0]  valid3;
  logic [7:0]  tag3 [3];
  logic [31:0] val3 [3];
  logic [2:0]  acc3;
  logic [7:0]  ctag3;
  logic [31:0] cval3;
  logic        cvld3;
  logic        busy3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_FU(4), .BIT_WIDTH(32), .TAG_WIDTH(8)) dut4 (
    .clk(clk), .reset(reset),
    .fu_resValid(valid4), .fu_resTag(tag4), .fu_resValue(val4),
    .fu_resAccept(acc4), .cdb_tag(ctag4), .cdb_value(cval4),
    .cdb_valid(cvld4), .busy(busy4)
  );

  cdb_arbiter #(.NUM_FU(3), .BIT_WIDTH(32), .TAG_WIDTH(8)) dut3 (
    .clk(clk), .reset(reset),
    .fu_resValid(valid3), .fu_resTag(tag3), .fu_resValue(val3),
    .fu_resAccept(acc3), .cdb_tag(ctag3), .cdb_value(cval3),
    .cdb_valid(cvld3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid4 = '0;
    valid3 = '0;
    for (int i = 0; i < 4; i++) begin
      tag4[i] = '0;
      val4[i] = '0;
    end
    for (int i = 0; i < 3; i++) begin
      tag3[i] = '0;
      val3[i] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [7:0] t0;
  logic       drv;
  logic       fa_v [9];
  logic [7:0] fa_t [9];

  initial begin
    idle();
    do_reset();
    chk("rst_valid", cvld4, 1'b0);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_acc", acc4, 4'hf);
    chk("rst_tag", ctag4, 8'h00);
    chk("rst_value", cval4, 32'h0);

    // Single result from FU1
    valid4[1] = 1'b1;
    tag4[1]   = 8'h05;
    val4[1]   = 32'hdeadbeef;
    step();
    idle();
    chk("single_busy", busy4, 1'b1);
    chk("single_early", cvld4, 1'b0);
    chk("single_acc", acc4, 4'hf);
    step();
    chk("single_valid", cvld4, 1'b1);
    chk("single_tag", ctag4, 8'h05);
    chk("single_value", cval4, 32'hdeadbeef);
    chk("single_busy_off", busy4, 1'b0);
    step();
    chk("single_once", cvld4, 1'b0);
    chk("single_hold", ctag4, 8'h05);

    // All four at once from rrPtr=0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      valid4[i] = 1'b1;
      tag4[i]   = 8'h10 + 8'(i);
      val4[i]   = 32'h1000 + 32'(i);
    end
    step();
    idle();
    chk("all_acc", acc4, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("all_valid", cvld4, 1'b1);
      chk("all_tag", ctag4, 8'h10 + 8'(i));
      chk("all_value", cval4, 32'h1000 + 32'(i));
    end
    // rrPtr back at 0: FU1 must beat FU3
    valid4[1] = 1'b1;
    tag4[1]   = 8'h41;
    valid4[3] = 1'b1;
    tag4[3]   = 8'h43;
    step();
    idle();
    chk("all_gap", cvld4, 1'b0);
    step();
    chk("ptr_first", ctag4, 8'h41);
    step();
    chk("ptr_second", ctag4, 8'h43);
    step();
    chk("ptr_idle", cvld4, 1'b0);

    // Fairness: FU0 streams, FU2 injects 0x22 once
    fa_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
             1'b1, 1'b1, 1'b1, 1'b0};
    fa_t = '{8'h00, 8'h80, 8'h22, 8'h81, 8'h82,
             8'h83, 8'h84, 8'h85, 8'h00};
    do_reset();
    t0 = 8'h80;
    for (int c = 0; c < 9; c++) begin
      drv       = (t0 <= 8'h85);
      valid4[0] = drv;
      tag4[0]   = t0;
      valid4[2] = (c == 1);
      tag4[2]   = 8'h22;
      if (c == 2) chk("fair_stall", acc4[0], 1'b0);
      if (drv && acc4[0]) t0 = t0 + 8'h01;
      step();
      chk("fair_valid", cvld4, fa_v[c]);
      if (fa_v[c]) chk("fair_tag", ctag4, fa_t[c]);
    end
    idle();
    chk("fair_busy", busy4, 1'b0);

    // Back-to-back from FU3 alone
    for (int i = 0; i < 10; i++) begin
      valid4[3] = (i < 8);
      tag4[3]   = 8'h30 + 8'(i);
      if (i < 8) chk("b2b_acc", acc4[3], 1'b1);
      step();
      if (i >= 1 && i <= 8) begin
        chk("b2b_valid", cvld4, 1'b1);
        chk("b2b_tag", ctag4, 8'h30 + 8'(i - 1));
      end
      if (i == 9) chk("b2b_end", cvld4, 1'b0);
    end
    idle();

    // Reset with three results pending
    for (int i = 0; i < 3; i++) begin
      valid4[i] = 1'b1;
      tag4[i]   = 8'ha0 + 8'(i);
    end
    step();
    idle();
    chk("mid_busy", busy4, 1'b1);
    do_reset();
    chk("mid_valid", cvld4, 1'b0);
    chk("mid_busy_off", busy4, 1'b0);
    chk("mid_acc", acc4, 4'hf);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mid_silent", cvld4, 1'b0);
    end

    // Valid held during reset must not be captured
    valid4 = 4'hf;
    reset  = 1'b1;
    step();
    step();
    reset = 1'b0;
    idle();
    chk("rst_nocap", busy4, 1'b0);
    step();
    chk("rst_nocast", cvld4, 1'b0);

    // NUM_FU=3 wrap: FU2 granted, then FU0 ahead of FU1
    do_reset();
    valid3[2] = 1'b1;
    tag3[2]   = 8'h52;
    step();
    idle();
    step();
    chk("wrap_fu2", ctag3, 8'h52);
    chk("wrap_fu2_v", cvld3, 1'b1);
    valid3[0] = 1'b1;
    tag3[0]   = 8'h50;
    valid3[1] = 1'b1;
    tag3[1]   = 8'h51;
    step();
    idle();
    step();
    chk("wrap_fu0", ctag3, 8'h50);
    step();
    chk("wrap_fu1", ctag3, 8'h51);
    step();
    chk("wrap_idle", cvld3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
